// File: rtl/mem_copy_dma.sv
// mem_copy_dma: block-copy engine, second master on the word memory.
// Copies len words src->dst, one read then one write per word.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, abort        copy request (IDLE only), cancel (RD/WR only)
//   src_addr, dst_addr  base word addresses, latched on accept
//   len                 word count, latched on accept
//   busy                high in RD and WR
//   done, aborted       one-cycle completion / cancel pulses
//   words_left          remaining word count
//   checksum            16-bit additive sum of written words
//   mem_rd, mem_wr      memory strobes, never both high
//   mem_addr, mem_wd    memory address / write data
//   mem_rdata           combinational memory read data
module mem_copy_dma #(
   parameter int AW = 12,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW-1:0] len,
   output logic          busy,
   output logic          done,
   output logic          aborted,
   output logic [AW-1:0] words_left,
   output logic [DW-1:0] checksum,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_DONE,
      S_ABT
   } state_t;

   state_t        state;
   logic [AW-1:0] src_ptr;
   logic [AW-1:0] dst_ptr;
   logic [DW-1:0] hold;

   // Outputs are registered and set on entry to the state that
   // owns them, so each one is a pure function of the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         src_ptr    <= '0;
         dst_ptr    <= '0;
         hold       <= '0;
         words_left <= '0;
         checksum   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_wd     <= '0;
      end else begin
         busy     <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
         mem_rd   <= 1'b0;
         mem_wr   <= 1'b0;
         mem_addr <= '0;
         mem_wd   <= '0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  checksum <= '0;
                  if (len != '0) begin
                     src_ptr    <= src_addr;
                     dst_ptr    <= dst_addr;
                     words_left <= len;
                     state      <= S_RD;
                     busy       <= 1'b1;
                     mem_rd     <= 1'b1;
                     mem_addr   <= src_addr;
                  end else begin
                     words_left <= '0;
                     state      <= S_DONE;
                     done       <= 1'b1;
                  end
               end
            end
            S_RD: begin
               // The read in flight always completes, even on abort.
               hold    <= mem_rdata;
               src_ptr <= src_ptr + AW'(1);
               if (abort) begin
                  state   <= S_ABT;
                  aborted <= 1'b1;
               end else begin
                  state    <= S_WR;
                  busy     <= 1'b1;
                  mem_wr   <= 1'b1;
                  mem_addr <= dst_ptr;
                  mem_wd   <= mem_rdata;
               end
            end
            S_WR: begin
               // The write commits at this edge regardless of abort.
               checksum   <= checksum + hold;
               dst_ptr    <= dst_ptr + AW'(1);
               words_left <= words_left - AW'(1);
               if (abort) begin
                  state   <= S_ABT;
                  aborted <= 1'b1;
               end else if (words_left == AW'(1)) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end else begin
                  state    <= S_RD;
                  busy     <= 1'b1;
                  mem_rd   <= 1'b1;
                  mem_addr <= src_ptr;
               end
            end
            S_DONE:  state <= S_IDLE;
            S_ABT:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: directed bench for mem_copy_dma.
// Word memory model lives here; expectations are hand-computed.
module tb_mem_copy_dma;

   localparam int AW = 12;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [AW-1:0] dst_addr = '0;
   logic [AW-1:0] len = '0;
   logic          busy;
   logic          done;
   logic          aborted;
   logic [AW-1:0] words_left;
   logic [DW-1:0] checksum;
   logic          mem_rd;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rdata;

   logic [DW-1:0] mem [0:4095];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;

   int n_cmp = 0;
   int n_bad = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int cyc_cnt = 0;
   int t0 = 0;
   int r0 = 0;
   int w0 = 0;
   int d0 = 0;
   int lat;

   always #5 clk = ~clk;

   mem_copy_dma #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .src_addr  (src_addr),
      .dst_addr  (dst_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .words_left(words_left),
      .checksum  (checksum),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wd    (mem_wd),
      .mem_rdata (mem_rdata)
   );

   assign mem_rdata = mem_rd ? mem[mem_addr] : '0;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (mem_wr) mem[mem_addr] <= mem_wd;
      rd_cnt   <= rd_cnt + int'(mem_rd);
      wr_cnt   <= wr_cnt + int'(mem_wr);
      done_cnt <= done_cnt + int'(done);
      cyc_cnt  <= cyc_cnt + 1;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      @(negedge clk);
      pl_en = 1'b1;
      pl_addr = a;
      pl_data = d;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   task automatic go(input logic [AW-1:0] s,
                     input logic [AW-1:0] d,
                     input logic [AW-1:0] l);
      @(negedge clk);
      src_addr = s;
      dst_addr = d;
      len = l;
      start = 1'b1;
      r0 = rd_cnt;
      w0 = wr_cnt;
      d0 = done_cnt;
      @(posedge clk);
      #1 start = 1'b0;
      t0 = cyc_cnt;
   endtask

   // Latency is the cycle index after accept; -1 on timeout.
   task automatic wait_done(output int l);
      l = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin
            l = cyc_cnt - t0 + 1;
            break;
         end
      end
   endtask

   initial begin
      #1;
      check("rst_ctl",
            32'({busy, done, aborted, mem_rd, mem_wr}), 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_cs", 32'(checksum), 0);
      check("rst_wl", 32'(words_left), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // basic two-word copy
      preload(64, 16'h0004);
      preload(65, 16'h0002);
      preload(200, 16'hdead);
      preload(201, 16'hdead);
      go(64, 200, 2);
      wait_done(lat);
      check("t1_lat", lat, 5);
      check("t1_m200", 32'(mem[200]), 32'h4);
      check("t1_m201", 32'(mem[201]), 32'h2);
      check("t1_cs", 32'(checksum), 32'h6);
      check("t1_wl", 32'(words_left), 0);
      check("t1_rd", rd_cnt - r0, 2);
      check("t1_wr", wr_cnt - w0, 2);
      @(negedge clk);
      check("t1_pulse", 32'({done, busy}), 0);

      // zero length
      go(5, 6, 0);
      wait_done(lat);
      check("t2_lat", lat, 1);
      check("t2_rd", rd_cnt - r0, 0);
      check("t2_wr", wr_cnt - w0, 0);
      check("t2_cs", 32'(checksum), 0);
      check("t2_wl", 32'(words_left), 0);

      // source wraps past 4095
      preload(4094, 1);
      preload(4095, 2);
      preload(0, 3);
      preload(1, 4);
      for (int i = 10; i < 14; i++) preload(AW'(i), 0);
      go(4094, 10, 4);
      wait_done(lat);
      check("t3_lat", lat, 9);
      check("t3_m10", 32'(mem[10]), 1);
      check("t3_m11", 32'(mem[11]), 2);
      check("t3_m12", 32'(mem[12]), 3);
      check("t3_m13", 32'(mem[13]), 4);
      check("t3_cs", 32'(checksum), 32'ha);

      // checksum overflow
      preload(300, 16'hffff);
      preload(301, 16'h0002);
      go(300, 310, 2);
      wait_done(lat);
      check("t4_cs", 32'(checksum), 32'h1);
      check("t4_m311", 32'(mem[311]), 32'h2);

      // overlapping ascending copy re-reads written words
      preload(100, 16'h00aa);
      preload(101, 1);
      preload(102, 2);
      preload(103, 3);
      go(100, 101, 3);
      wait_done(lat);
      check("t5_m101", 32'(mem[101]), 32'haa);
      check("t5_m102", 32'(mem[102]), 32'haa);
      check("t5_m103", 32'(mem[103]), 32'haa);
      check("t5_cs", 32'(checksum), 32'h1fe);

      // abort during the second write of a five-word copy
      for (int i = 0; i < 5; i++) begin
         preload(AW'(500 + i), DW'(16'h10 + i));
         preload(AW'(600 + i), 16'hdead);
      end
      go(500, 600, 5);
      repeat (3) @(negedge clk);
      @(negedge clk);
      check("t6_in_wr", 32'({mem_wr, mem_addr}), 32'h1259);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      check("t6_abt", 32'({aborted, busy}), 32'h2);
      check("t6_m601", 32'(mem[601]), 32'h11);
      check("t6_m602", 32'(mem[602]), 32'hdead);
      check("t6_wl", 32'(words_left), 3);
      check("t6_cs", 32'(checksum), 32'h21);
      @(negedge clk);
      check("t6_pulse", 32'(aborted), 0);
      check("t6_nodone", done_cnt - d0, 0);

      // reset in the middle of a copy
      preload(700, 16'hdead);
      go(500, 700, 5);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t7_ctl",
            32'({busy, done, aborted, mem_rd, mem_wr}), 0);
      check("t7_addr", 32'(mem_addr), 0);
      check("t7_wd", 32'(mem_wd), 0);
      check("t7_wl", 32'(words_left), 0);
      check("t7_cs", 32'(checksum), 0);
      @(negedge clk);
      rst_n = 1'b1;
      check("t7_lost", 32'(mem[700]), 32'hdead);

      // start while busy is ignored
      preload(700, 1);
      preload(701, 2);
      preload(702, 3);
      preload(950, 16'hbeef);
      go(700, 800, 3);
      repeat (2) @(negedge clk);
      src_addr = 900;
      dst_addr = 950;
      len = 1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(lat);
      check("t8_lat", lat, 7);
      check("t8_m800", 32'(mem[800]), 1);
      check("t8_m802", 32'(mem[802]), 3);
      check("t8_cs", 32'(checksum), 6);
      check("t8_m950", 32'(mem[950]), 32'hbeef);
      @(negedge clk);
      @(negedge clk);
      check("t8_idle", 32'({busy, mem_rd, mem_wr}), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
